// File: rtl/midi_poly.sv
// Polyphonic MIDI decoder: channel-filtered parser with running status that drives VOICES gate/note/velocity slots.
// Outputs update one CE cycle after the final data byte; CE=0 freezes everything and no backpressure exists.
module midi_poly #(
  parameter int VOICES  = 4,
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic [7:0]            DATA,
  input  logic                  DV,
  output logic [7*VOICES-1:0]   NOTE_NUM,
  output logic [7*VOICES-1:0]   NOTE_VEL,
  output logic [VOICES-1:0]     GATE,
  output logic [6:0]            PROGRAM
);

  localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [2:0] {
    S_WAIT, S_D1, S_D2, S_PROG, S_SKIP1, S_SKIP2, S_H_NOTE, S_H_PROG
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              rs_q, rs_d;
  logic                    rs_vld_q, rs_vld_d;
  logic [6:0]              dat_q, dat_d, vel_q, vel_d, prog_q, prog_d;
  logic [VOICES-1:0][6:0]  vnote_q, vnote_d, vvel_q, vvel_d;
  logic [VOICES-1:0]       gate_q, gate_d;
  logic [PW-1:0]           ptr_q, ptr_d;

  logic                    chan_ok, is_on, hit, free;
  logic [PW-1:0]           hit_idx, free_idx, tgt;

  assign chan_ok = (OMNI != 0) || (DATA[3:0] == 4'(CHANNEL));

  // Retrigger a gated voice holding the note, else lowest free voice, else steal.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!hit && gate_q[i] && (vnote_q[i] == dat_q)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
      if (!free && !gate_q[i]) begin
        free     = 1'b1;
        free_idx = PW'(i);
      end
    end
    tgt   = hit ? hit_idx : (free ? free_idx : ptr_q);
    is_on = rs_q[4] && (vel_q != 7'd0);
  end

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rs_vld_d = rs_vld_q;
    dat_d    = dat_q;
    vel_d    = vel_q;
    prog_d   = prog_q;
    vnote_d  = vnote_q;
    vvel_d   = vvel_q;
    gate_d   = gate_q;
    ptr_d    = ptr_q;
    if (CE) begin
      case (state_q)
        S_H_NOTE: begin
          state_d = S_WAIT;
          if (is_on) begin
            vnote_d[tgt] = dat_q;
            vvel_d[tgt]  = vel_q;
            gate_d[tgt]  = 1'b1;
            if (!hit && !free) ptr_d = (ptr_q == PW'(VOICES - 1)) ? '0 : ptr_q + PW'(1);
          end else begin
            for (int i = 0; i < VOICES; i++) begin
              if (gate_q[i] && (vnote_q[i] == dat_q)) begin
                gate_d[i] = 1'b0;
                vvel_d[i] = '0;
              end
            end
          end
        end
        S_H_PROG: begin
          prog_d  = dat_q;
          state_d = S_WAIT;
        end
        default: begin
          if (DV) begin
            if (DATA >= 8'hF8) begin
              state_d = state_q;
            end else if (DATA >= 8'hF0) begin
              rs_vld_d = 1'b0;
              state_d  = S_WAIT;
            end else if (DATA[7]) begin
              rs_vld_d = 1'b0;
              // 0xCn/0xDn carry one data byte, every other channel message two.
              if (!chan_ok) begin
                state_d = (DATA[6:5] == 2'b10) ? S_SKIP1 : S_SKIP2;
              end else begin
                case (DATA[6:4])
                  3'b000, 3'b001: begin
                    rs_vld_d = 1'b1;
                    rs_d     = DATA;
                    state_d  = S_D1;
                  end
                  3'b100: begin
                    rs_vld_d = 1'b1;
                    rs_d     = DATA;
                    state_d  = S_PROG;
                  end
                  3'b101:  state_d = S_SKIP1;
                  default: state_d = S_SKIP2;
                endcase
              end
            end else begin
              case (state_q)
                S_WAIT: begin
                  if (rs_vld_q) begin
                    dat_d   = DATA[6:0];
                    state_d = (rs_q[6:5] == 2'b00) ? S_D2 : S_H_PROG;
                  end
                end
                S_D1: begin
                  dat_d   = DATA[6:0];
                  state_d = S_D2;
                end
                S_D2: begin
                  vel_d   = DATA[6:0];
                  state_d = S_H_NOTE;
                end
                S_PROG: begin
                  dat_d   = DATA[6:0];
                  state_d = S_H_PROG;
                end
                S_SKIP2: state_d = S_SKIP1;
                S_SKIP1: state_d = S_WAIT;
                default: state_d = state_q;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_WAIT;
      rs_q     <= '0;
      rs_vld_q <= 1'b0;
      dat_q    <= '0;
      vel_q    <= '0;
      prog_q   <= '0;
      vnote_q  <= '0;
      vvel_q   <= '0;
      gate_q   <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      rs_vld_q <= rs_vld_d;
      dat_q    <= dat_d;
      vel_q    <= vel_d;
      prog_q   <= prog_d;
      vnote_q  <= vnote_d;
      vvel_q   <= vvel_d;
      gate_q   <= gate_d;
      ptr_q    <= ptr_d;
    end
  end

  assign NOTE_NUM = vnote_q;
  assign NOTE_VEL = vvel_q;
  assign GATE     = gate_q;
  assign PROGRAM  = prog_q;

endmodule

// File: tb/tb_midi_poly.sv
// Bench for midi_poly: two instances (4 voices on channel 0, 3 voices omni) share one byte stream
// and are compared against a message-level reference model after every accepted byte.
module tb_midi_poly;

  logic        CLK = 1'b0;
  logic        RST, CE, DV;
  logic [7:0]  DATA;
  logic [27:0] nn_a, nv_a;
  logic [3:0]  g_a;
  logic [6:0]  p_a;
  logic [20:0] nn_b, nv_b;
  logic [2:0]  g_b;
  logic [6:0]  p_b;

  int checks = 0;
  int errors = 0;

  midi_poly #(.VOICES(4), .CHANNEL(0), .OMNI(0)) dut_a (
    .CLK(CLK), .RST(RST), .CE(CE), .DATA(DATA), .DV(DV),
    .NOTE_NUM(nn_a), .NOTE_VEL(nv_a), .GATE(g_a), .PROGRAM(p_a)
  );

  midi_poly #(.VOICES(3), .CHANNEL(0), .OMNI(1)) dut_b (
    .CLK(CLK), .RST(RST), .CE(CE), .DATA(DATA), .DV(DV),
    .NOTE_NUM(nn_b), .NOTE_VEL(nv_b), .GATE(g_b), .PROGRAM(p_b)
  );

  always #5 CLK = ~CLK;

  // Reference model: message-level parser plus voice table, one slot per instance.
  int nv_p[2]   = '{4, 3};
  int ch_p[2]   = '{0, 0};
  int omni_p[2] = '{0, 1};
  int rs[2], mode[2], cnt[2], gcount[2], pend[2], pend_on[2], ptr[2], prog[2];
  int got[2][2];
  int vn[2][16], vv[2][16], vg[2][16];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rs[m] = -1; mode[m] = 0; cnt[m] = 0; gcount[m] = 0;
      pend[m] = 0; pend_on[m] = 0; ptr[m] = 0; prog[m] = 0;
      for (int i = 0; i < 16; i++) begin
        vn[m][i] = 0; vv[m][i] = 0; vg[m][i] = 0;
      end
    end
  endtask

  task automatic model_byte(input int m, input int b);
    int hi;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      rs[m] = -1; mode[m] = 0;
      return;
    end
    if (b >= 'h80) begin
      hi = b >> 4;
      cnt[m] = (hi == 12 || hi == 13) ? 1 : 2;
      gcount[m] = 0;
      if ((omni_p[m] != 0 || (b & 15) == ch_p[m]) && (hi == 8 || hi == 9 || hi == 12)) begin
        rs[m] = b; mode[m] = 1;
      end else begin
        rs[m] = -1; mode[m] = 2;
      end
      return;
    end
    if (mode[m] == 2) begin
      cnt[m]--;
      if (cnt[m] == 0) mode[m] = 0;
      return;
    end
    if (mode[m] == 0) begin
      if (rs[m] < 0) return;
      mode[m] = 1; gcount[m] = 0;
      cnt[m] = ((rs[m] >> 4) == 12) ? 1 : 2;
    end
    got[m][gcount[m]] = b;
    gcount[m]++;
    cnt[m]--;
    if (cnt[m] == 0) begin
      mode[m] = 0;
      if ((rs[m] >> 4) == 12) pend[m] = 2;
      else begin
        pend[m] = 1;
        pend_on[m] = ((rs[m] >> 4) == 9 && got[m][1] > 0) ? 1 : 0;
      end
    end
  endtask

  task automatic model_apply(input int m);
    int t;
    if (pend[m] == 2) prog[m] = got[m][0];
    if (pend[m] == 1) begin
      if (pend_on[m] != 0) begin
        t = -1;
        for (int i = 0; i < nv_p[m]; i++)
          if (t < 0 && vg[m][i] != 0 && vn[m][i] == got[m][0]) t = i;
        for (int i = 0; i < nv_p[m]; i++)
          if (t < 0 && vg[m][i] == 0) t = i;
        if (t < 0) begin
          t = ptr[m];
          ptr[m] = (ptr[m] + 1) % nv_p[m];
        end
        vn[m][t] = got[m][0]; vv[m][t] = got[m][1]; vg[m][t] = 1;
      end else begin
        for (int i = 0; i < nv_p[m]; i++)
          if (vg[m][i] != 0 && vn[m][i] == got[m][0]) begin
            vg[m][i] = 0; vv[m][i] = 0;
          end
      end
    end
    pend[m] = 0;
  endtask

  function automatic logic [111:0] exp_vec(input int m, input int which);
    logic [111:0] v;
    v = '0;
    if (which == 3) v[6:0] = 7'(prog[m]);
    else
      for (int i = 0; i < nv_p[m]; i++) begin
        if (which == 0) v[7*i +: 7] = 7'(vn[m][i]);
        if (which == 1) v[7*i +: 7] = 7'(vv[m][i]);
        if (which == 2) v[i] = (vg[m][i] != 0);
      end
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    cmp({tag, "_A_note"}, 112'(nn_a), exp_vec(0, 0));
    cmp({tag, "_A_vel"},  112'(nv_a), exp_vec(0, 1));
    cmp({tag, "_A_gate"}, 112'(g_a),  exp_vec(0, 2));
    cmp({tag, "_A_prog"}, 112'(p_a),  exp_vec(0, 3));
    cmp({tag, "_B_note"}, 112'(nn_b), exp_vec(1, 0));
    cmp({tag, "_B_vel"},  112'(nv_b), exp_vec(1, 1));
    cmp({tag, "_B_gate"}, 112'(g_b),  exp_vec(1, 2));
    cmp({tag, "_B_prog"}, 112'(p_b),  exp_vec(1, 3));
  endtask

  task automatic tick(input logic ce, input logic dv, input logic [7:0] d);
    CE = ce; DV = dv; DATA = d;
    @(posedge CLK);
    #1;
  endtask

  // One accepted byte, with CE=0 noise before it and a stretched hold cycle after it.
  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    tick(1'b1, 1'b1, b);
    model_byte(0, int'(b));
    model_byte(1, int'(b));
    check("acc");
    repeat ($urandom_range(0, 1)) begin
      tick(1'b0, 1'b0, 8'h00);
      check("hold");
    end
    tick(1'b1, 1'b0, 8'h00);
    model_apply(0);
    model_apply(1);
    check("post");
    tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(1'b0, 1'b1, 8'h90);
    tick(1'b1, 1'b1, 8'h3C);
    RST = 1'b0;
    model_reset();
    check("rst");
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    RST = 1'b1; CE = 1'b0; DV = 1'b0; DATA = 8'h00;
    @(posedge CLK);
    #1;
    do_reset();

    send_list('{8'h90, 8'h3C, 8'h64});
    cmp("t1_gate", 112'(g_a), 112'(4'b0001));
    cmp("t1_note0", 112'(nn_a), 112'(7'h3C));
    cmp("t1_vel0", 112'(nv_a), 112'(7'h64));

    do_reset();
    send_list('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h43, 8'h00});
    cmp("t2_gate_on", 112'(g_a), 112'(4'b0011));
    send_list('{8'h80, 8'h3C, 8'h00});
    cmp("t2_gate_off", 112'(g_a), 112'(4'b0010));
    cmp("t2_vel0", 112'(nv_a[6:0]), 112'(7'h00));
    cmp("t2_note0", 112'(nn_a[6:0]), 112'(7'h3C));

    do_reset();
    send_list('{8'h90, 8'h30, 8'h64, 8'h31, 8'h64, 8'h32, 8'h64, 8'h33, 8'h64, 8'h34, 8'h64});
    cmp("t3_steal0", 112'(nn_a), 112'({7'h33, 7'h32, 7'h31, 7'h34}));
    send_list('{8'h35, 8'h64});
    cmp("t3_steal1", 112'(nn_a), 112'({7'h33, 7'h32, 7'h35, 7'h34}));

    do_reset();
    send_list('{8'h91, 8'h3C, 8'h64});
    cmp("t4_chan_a", 112'(g_a), 112'(4'b0000));
    cmp("t4_omni_b", 112'(g_b), 112'(3'b001));

    do_reset();
    send_list('{8'hC0, 8'h05});
    cmp("t5_prog", 112'(p_a), 112'(7'd5));
    send_list('{8'hB0, 8'h07, 8'h7F, 8'h10});
    cmp("t5_prog_kept", 112'(p_a), 112'(7'd5));
    cmp("t5_voices", 112'(g_a), 112'(4'b0000));

    do_reset();
    send_list('{8'h90, 8'h3C, 8'hF8, 8'h64});
    cmp("t6_rt", 112'(g_a), 112'(4'b0001));
    send_list('{8'h90, 8'h3D, 8'hF0, 8'h64});
    cmp("t6_sysex", 112'(nn_a[13:7]), 112'(7'h00));
    send_list('{8'h90, 8'h3E});
    RST = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    RST = 1'b0;
    model_reset();
    check("t6_midrst");
    cmp("t6_rst_gate", 112'(g_a), 112'(4'b0000));
    send(8'h64);
    cmp("t6_dropped", 112'(g_a), 112'(4'b0000));

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) b = 8'($urandom_range('hF8, 'hFF));
      else if (r < 9) b = 8'($urandom_range('hF0, 'hF7));
      else if (r < 40) begin
        case ($urandom_range(0, 7))
          0: b = 8'h80; 1, 2: b = 8'h90; 3: b = 8'hC0;
          4: b = 8'hB0; 5: b = 8'hD0; 6: b = 8'hE0; default: b = 8'hA0;
        endcase
        b[3:0] = 4'($urandom_range(0, 1));
      end else if ($urandom_range(0, 3) == 0) b = 8'h00;
      else if ($urandom_range(0, 1) == 0) b = 8'(8'h30 + $urandom_range(0, 5));
      else b = 8'($urandom_range(0, 127));
      send(b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
